// File: rtl/input_port_buffer.sv
// Per-input-port flit FIFO with route-header generation and U-turn discard.
// Optional macro INPUT_PORT_STATS_EN adds saturating forward/drop counters.
module input_port_buffer #(
    parameter int flitWidth         = 12,
    parameter int flitWidthModified = 14,
    parameter int headerWidth       = 4,
    parameter int DEPTH             = 4,
    parameter int PORT_ID           = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [flitWidth-1:0]         in_flit,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         portBlock,
    output logic [flitWidthModified-1:0] outData,
    output logic                         empty,
    output logic                         drop_pulse
`ifdef INPUT_PORT_STATS_EN
    ,
    output logic [7:0]                   fwd_count,
    output logic [7:0]                   drop_count
`endif
);

    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DEST_LSB = flitWidth - headerWidth;
    localparam logic [1:0] PID = 2'(PORT_ID);

    // Handshake: a flit transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on occupancy, never on the same-cycle pop.
    logic [flitWidth-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;

    logic                 w_empty;
    logic                 w_full;
    logic [flitWidth-1:0] w_head;
    logic [1:0]           w_route;
    logic                 w_uturn;
    logic                 w_fwd;
    logic                 w_pop;
    logic                 w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_head  = r_mem[r_rd_ptr];
    // Route is the top two bits of the destination field.
    assign w_route = w_head[DEST_LSB + headerWidth - 1 -: 2];
    assign w_uturn = !w_empty && (w_route == PID);
    assign w_fwd   = !w_empty && !portBlock && !w_uturn;
    assign w_pop   = w_fwd || w_uturn;
    assign w_push  = in_valid && !w_full;

    assign in_ready   = !w_full;
    assign empty      = w_empty;
    assign drop_pulse = w_uturn;
    // Idle lane carries its own port id so no output arbiter ever matches it.
    assign outData    = (w_empty || w_uturn) ? {PID, {flitWidth{1'b0}}}
                                             : {w_route, w_head};

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= in_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef INPUT_PORT_STATS_EN
    logic [7:0] r_fwd_count;
    logic [7:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fwd_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_fwd && (r_fwd_count != 8'hFF)) begin
                r_fwd_count <= r_fwd_count + 8'd1;
            end
            if (w_uturn && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign fwd_count  = r_fwd_count;
    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_input_port_buffer.sv
// Bench for input_port_buffer: two instances (PORT_ID 0 and 2) on shared stimulus,
// checked every cycle against a queue-based model plus directed literal checks.
module tb_input_port_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [11:0] in_flit;
    logic        in_valid;
    logic        port_block;

    logic        rdy  [2];
    logic [13:0] od   [2];
    logic        emp  [2];
    logic        drp  [2];
`ifdef INPUT_PORT_STATS_EN
    logic [7:0]  fcnt [2];
    logic [7:0]  dcnt [2];
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Behavioural model: one flit queue and two saturating counters per instance.
    logic [11:0] mq [2][$];
    int          mfwd  [2];
    int          mdrop [2];
    logic [1:0]  pid   [2];

    initial begin
        pid[0] = 2'd0;
        pid[1] = 2'd2;
    end

    input_port_buffer #(.PORT_ID(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid),
        .in_ready(rdy[0]), .portBlock(port_block), .outData(od[0]),
        .empty(emp[0]), .drop_pulse(drp[0])
`ifdef INPUT_PORT_STATS_EN
        , .fwd_count(fcnt[0]), .drop_count(dcnt[0])
`endif
    );

    input_port_buffer #(.PORT_ID(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid),
        .in_ready(rdy[1]), .portBlock(port_block), .outData(od[1]),
        .empty(emp[1]), .drop_pulse(drp[1])
`ifdef INPUT_PORT_STATS_EN
        , .fwd_count(fcnt[1]), .drop_count(dcnt[1])
`endif
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on the active edge from the inputs the DUTs sample.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mq[k].delete();
                mfwd[k]  = 0;
                mdrop[k] = 0;
            end else begin
                automatic int  sz    = mq[k].size();
                automatic bit  push  = in_valid && (sz < DEPTH);
                automatic bit  uturn = (sz > 0) && (mq[k][0][11:10] == pid[k]);
                automatic bit  fwd   = (sz > 0) && !uturn && !port_block;
                if (uturn) begin
                    void'(mq[k].pop_front());
                    if (mdrop[k] < 255) mdrop[k]++;
                end else if (fwd) begin
                    void'(mq[k].pop_front());
                    if (mfwd[k] < 255) mfwd[k]++;
                end
                if (push) mq[k].push_back(in_flit);
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                automatic bit          e_empty = (mq[k].size() == 0);
                automatic logic [11:0] head    = e_empty ? 12'h000 : mq[k][0];
                automatic bit          e_uturn = !e_empty && (head[11:10] == pid[k]);
                automatic logic [13:0] e_out   = (e_empty || e_uturn) ? {pid[k], 12'h000}
                                                                      : {head[11:10], head};
                chk($sformatf("outData[%0d]", k), 32'(od[k]), 32'(e_out));
                chk($sformatf("empty[%0d]", k), 32'(emp[k]), 32'(e_empty));
                chk($sformatf("in_ready[%0d]", k), 32'(rdy[k]), 32'(mq[k].size() < DEPTH));
                chk($sformatf("drop_pulse[%0d]", k), 32'(drp[k]), 32'(e_uturn));
`ifdef INPUT_PORT_STATS_EN
                chk($sformatf("fwd_count[%0d]", k), 32'(fcnt[k]), 32'(mfwd[k]));
                chk($sformatf("drop_count[%0d]", k), 32'(dcnt[k]), 32'(mdrop[k]));
`endif
            end
        end
    end

    // Driver: hold inputs across one active edge, then settle 1 time unit past it.
    task automatic cyc(input logic v, input logic [11:0] f, input logic b);
        in_valid   = v;
        in_flit    = f;
        port_block = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 12'h000, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_flit = '0;
        port_block = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1;
        cyc(1'b0, 12'h000, 1'b0);
        rst_n = 1'b1;

        // Reset / idle state
        chk("rst_out0", 32'(od[0]), 32'h0000);
        chk("rst_out2", 32'(od[1]), 32'h2000);
        chk("rst_empty", 32'(emp[0]), 32'd1);
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_drop", 32'(drp[0]), 32'd0);

        // Zero-bubble push then pop
        cyc(1'b1, 12'h8A5, 1'b0);
        chk("push_8a5_out0", 32'(od[0]), 32'h28A5);
        chk("push_8a5_empty0", 32'(emp[0]), 32'd0);
        chk("uturn_8a5_drop2", 32'(drp[1]), 32'd1);
        cyc(1'b0, 12'h000, 1'b0);
        chk("pop_8a5_empty0", 32'(emp[0]), 32'd1);

        // Blocked fill, refused fifth flit, then drain in order
        cyc(1'b1, 12'h4AA, 1'b1);
        cyc(1'b1, 12'h811, 1'b1);
        cyc(1'b1, 12'hC22, 1'b1);
        cyc(1'b1, 12'h433, 1'b1);
        chk("full_ready0", 32'(rdy[0]), 32'd0);
        chk("full_head0", 32'(od[0]), 32'h14AA);
        cyc(1'b1, 12'h555, 1'b1);
        chk("refused_head0", 32'(od[0]), 32'h14AA);
        cyc(1'b0, 12'h000, 1'b0);
        chk("drain1", 32'(od[0]), 32'h2811);
        cyc(1'b0, 12'h000, 1'b0);
        chk("drain2", 32'(od[0]), 32'h3C22);
        cyc(1'b0, 12'h000, 1'b0);
        chk("drain3", 32'(od[0]), 32'h1433);
        cyc(1'b0, 12'h000, 1'b0);
        chk("drain_empty", 32'(emp[0]), 32'd1);
        idle(6);

        // U-turn discard on PORT_ID=2
        cyc(1'b1, 12'h9FF, 1'b0);
        chk("uturn_drop2", 32'(drp[1]), 32'd1);
        chk("uturn_out2", 32'(od[1]), 32'h2000);
        cyc(1'b1, 12'h0F0, 1'b0);
        chk("after_uturn_out2", 32'(od[1]), 32'h00F0);
        chk("after_uturn_drop2", 32'(drp[1]), 32'd0);
        idle(6);

        // Simultaneous push/pop at count=2 keeps count at 2
        cyc(1'b1, 12'h4A1, 1'b1);
        cyc(1'b1, 12'h8B2, 1'b1);
        cyc(1'b1, 12'hC33, 1'b0);
        chk("pushpop_head0", 32'(od[0]), 32'h28B2);
        cyc(1'b1, 12'h555, 1'b1);
        chk("pushpop_ready_a", 32'(rdy[0]), 32'd1);
        cyc(1'b1, 12'h666, 1'b1);
        chk("pushpop_ready_b", 32'(rdy[0]), 32'd0);
        idle(8);

        // Randomized traffic; the compare process checks every cycle
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 2) == 0));
        end
        idle(8);

        // Long unblocked stream of legal flits for both instances (routes 1 or 3)
        for (int i = 0; i < 320; i++) begin
            automatic logic [11:0] f = 12'($urandom);
            f[10] = 1'b1;
            cyc(1'b1, f, 1'b0);
        end
`ifdef INPUT_PORT_STATS_EN
        chk("fwd_sat0", 32'(fcnt[0]), 32'hFF);
        chk("fwd_sat2", 32'(fcnt[1]), 32'hFF);
`endif

        // Reset mid-stream
        cyc(1'b1, 12'h4C4, 1'b1);
        cyc(1'b1, 12'h4C5, 1'b1);
        rst_n = 1'b0;
        cyc(1'b1, 12'h4C6, 1'b1);
        rst_n = 1'b1;
        chk("midrst_empty0", 32'(emp[0]), 32'd1);
        chk("midrst_out0", 32'(od[0]), 32'h0000);
`ifdef INPUT_PORT_STATS_EN
        chk("midrst_fwd0", 32'(fcnt[0]), 32'h00);
        chk("midrst_drop2", 32'(dcnt[1]), 32'h00);
`endif
        idle(4);

        @(negedge clk);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_port_buffer.md
Name: input_port_buffer

Overview:
- Per-input-port FIFO stage that sits directly upstream of an output port.
- Accepts raw 12-bit flits from a link with a valid/ready handshake, buffers them, and computes a 2-bit route header from the head flit.
- Presents the 14-bit modified word {route, flit} on the data1..data4 lane of the output port it feeds.
- Pops the head when the output port's arbiter does not assert block.
- Four instances per router, one per input, with PORT_ID = 0..3.

Parameters:
- flitWidth, 12, raw flit width.
- flitWidthModified, 14, flit plus 2-bit route header.
- headerWidth, 4, destination field at flit[flitWidth-1 -: headerWidth].
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PORT_ID, 0, 2-bit index of this input port.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_flit  input  flitWidth  incoming raw flit.
- in_valid  input  1  in_flit valid.
- in_ready  output  1  buffer can accept (= !full).
- portBlock  input  1  head blocked by downstream arbiter; combinational from the output port, already selected by router top-level wiring.
- outData  output  flitWidthModified  {route[1:0], head flit}; idle encoding when empty.
- empty  output  1  FIFO holds no flits.
- drop_pulse  output  1  one-cycle pulse when an illegal U-turn flit is discarded.

Behaviour:
- Reset (rst_n=0 at posedge):
  - read/write pointers and count = 0.
  - empty=1, in_ready=1, drop_pulse=0.
  - outData = idle encoding.
  - FIFO contents are don't-care.
- Push: in_valid && in_ready at posedge writes in_flit to wr_ptr; wr_ptr and count increment. Pointers wrap modulo DEPTH.
- in_ready = (count != DEPTH). It is not a function of pop, so a full FIFO refuses a push even in a cycle where it pops.
- Route: route = head_flit[flitWidth-1 -: 2], i.e. the top 2 destination bits select the output port index. Computed combinationally from the head entry.
- Legal pop: !empty && !portBlock && route != PORT_ID at posedge; rd_ptr increments, count decrements.
- U-turn drop: !empty && route == PORT_ID. The head is popped unconditionally (portBlock ignored) and drop_pulse=1 for that cycle. The flit never reaches outData.
- outData is combinational from the head entry:
  - non-empty, legal route: {route, head_flit}.
  - empty or U-turn head: {PORT_ID, 12'h000}. No output port matches its own feeding input, so an idle lane never requests arbitration.
- Latency: a flit pushed at edge N appears on outData after edge N (zero bubble from empty). It leaves at the first edge with portBlock=0.
- Simultaneous push and pop (not full): count unchanged, both pointers advance. When count=1, the new flit becomes head next cycle.
- Ordering is strictly FIFO; no reordering across routes.
- portBlock held high indefinitely: the head is held stable and the FIFO fills, then in_ready=0.
- Reset mid-operation: all buffered flits are discarded; no partial state survives.
- in_valid while in_ready=0: the flit is ignored and the upstream link must hold it.

Optional Feature:
- Macro: INPUT_PORT_STATS_EN.
- Defined:
  - Adds output fwd_count [7:0], which increments on each legal pop and saturates at 8'hFF.
  - Adds output drop_count [7:0], which increments on each U-turn drop and saturates.
  - Both reset to 0.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Reset then idle, PORT_ID=0 -> outData=14'h0000, empty=1, in_ready=1, drop_pulse=0.
- PORT_ID=0; push 12'h8A5 with portBlock=0 -> next cycle outData=14'h28A5; following edge pops it, empty=1.
- portBlock=1; push 12'h4AA, 12'h811, 12'hC22, 12'h433 -> in_ready=0 after 4th push and 5th in_valid is ignored; release portBlock -> outData sequence 0x14AA, 0x2811, 0x3C22, 0x1433 on consecutive cycles.
- PORT_ID=2; push 12'h9FF (route 2) -> drop_pulse=1 for one cycle, outData stays 14'h2000, next flit 12'h0F0 emerges as 14'h00F0.
- FIFO at count=2, simultaneous push and pop -> count stays 2; 20 random flits under random portBlock and in_valid -> output order equals input order and wrap-around is exercised.
- INPUT_PORT_STATS_EN: 300 legal pops -> fwd_count=8'hFF, saturated; rst_n=0 mid-stream -> counters=0, empty=1.
